// File: rtl/edge_pkg.sv
// Shared types and defaults for the frame address generator.
// Imported by the interface, the raster counter and the top.
package edge_pkg;

  localparam int unsigned DefBusWidth      = 32;
  localparam int unsigned DefDimBits       = 16;
  localparam int unsigned DefBytesPerPixel = 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDone,
    StErr
  } fag_state_t;

endpackage

// File: rtl/frame_addr_gen_if.sv
// Pixel read-address handshake between the address generator (master)
// and the pixel-fetch block (slave).
interface frame_addr_gen_if
  import edge_pkg::*;
#(
  parameter int unsigned BUSWIDTH = DefBusWidth,
  parameter int unsigned DIM_BITS = DefDimBits
);

  logic                rd_valid;
  logic                rd_ready;
  logic [BUSWIDTH-1:0] rd_addr;
  logic [DIM_BITS-1:0] row;
  logic [DIM_BITS-1:0] col;
  logic                eol;
  logic                eof;

  modport master (
    output rd_valid,
    output rd_addr,
    output row,
    output col,
    output eol,
    output eof,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_addr,
    input  row,
    input  col,
    input  eol,
    input  eof,
    output rd_ready
  );

endinterface

// File: rtl/raster_counter.sv
// Raster-order column/row counters. Cleared at frame load, stepped once per
// accepted pixel, and wrapped at the latched width/height.
module raster_counter
  import edge_pkg::*;
#(
  parameter int unsigned DIM_BITS = DefDimBits
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                advance,
  input  logic [DIM_BITS-1:0] w,
  input  logic [DIM_BITS-1:0] h,
  output logic [DIM_BITS-1:0] col,
  output logic [DIM_BITS-1:0] row,
  output logic                eol,
  output logic                eof
);

  logic [DIM_BITS-1:0] col_q, col_d;
  logic [DIM_BITS-1:0] row_q, row_d;

  always_comb begin
    eol = (col_q == (w - DIM_BITS'(1)));
    eof = eol & (row_q == (h - DIM_BITS'(1)));
  end

  // Stepping on the final pixel holds the counters; the owner stops the walk there.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (!eol) begin
        col_d = col_q + DIM_BITS'(1);
      end else if (!eof) begin
        col_d = '0;
        row_d = row_q + DIM_BITS'(1);
      end
    end
  end

  always_ff @(posedge ahb_hclk) begin
    if (!n_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/frame_addr_gen.sv
// Frame address generator: latches geometry on a start edge and issues one
// pixel byte address per valid/ready handshake in raster order.
module frame_addr_gen
  import edge_pkg::*;
#(
  parameter int unsigned BUSWIDTH        = DefBusWidth,
  parameter int unsigned DIM_BITS        = DefDimBits,
  parameter int unsigned BYTES_PER_PIXEL = DefBytesPerPixel
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [BUSWIDTH-1:0] width,
  input  logic [BUSWIDTH-1:0] height,
  input  logic [BUSWIDTH-1:0] readStartAddress,
  frame_addr_gen_if.master    rd,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  fag_state_t          state_q;
  logic                start_q;
  logic                start_pulse;
  logic [DIM_BITS-1:0] w_q;
  logic [DIM_BITS-1:0] h_q;
  logic [BUSWIDTH-1:0] addr_q;
  logic                rd_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                cfg_err_q;

  logic                geom_ok;
  logic                handshake;
  logic                cnt_clear;
  logic                cnt_advance;
  logic                eol_raw;
  logic                eof_raw;
  logic [DIM_BITS-1:0] row_cnt;
  logic [DIM_BITS-1:0] col_cnt;

  assign start_pulse = start & ~start_q;
  assign handshake   = rd_valid_q & rd.rd_ready;
  assign cnt_clear   = (state_q == StLoad);
  assign cnt_advance = handshake & ~eof_raw;

  // Any bit at or above DIM_BITS makes the geometry unrepresentable.
  assign geom_ok = (width != '0) && (height != '0) &&
                   ((width >> DIM_BITS) == '0) && ((height >> DIM_BITS) == '0);

  raster_counter #(
    .DIM_BITS (DIM_BITS)
  ) u_raster_counter (
    .ahb_hclk (ahb_hclk),
    .n_rst    (n_rst),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .w        (w_q),
    .h        (h_q),
    .col      (col_cnt),
    .row      (row_cnt),
    .eol      (eol_raw),
    .eof      (eof_raw)
  );

  always_ff @(posedge ahb_hclk) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      w_q        <= '0;
      h_q        <= '0;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        StIdle: begin
          if (start_pulse) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          w_q    <= width[DIM_BITS-1:0];
          h_q    <= height[DIM_BITS-1:0];
          addr_q <= readStartAddress;
          if (geom_ok) begin
            state_q    <= StRun;
            rd_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state_q   <= StErr;
            cfg_err_q <= 1'b1;
          end
        end
        StRun: begin
          if (handshake) begin
            if (eof_raw) begin
              state_q    <= StDone;
              rd_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              // Rows are contiguous, so the address simply strides per pixel.
              addr_q <= addr_q + BUSWIDTH'(BYTES_PER_PIXEL);
            end
          end
        end
        StDone: begin
          if (!start) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        StErr: begin
          if (!start) begin
            state_q   <= StIdle;
            cfg_err_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_addr  = addr_q;
  assign rd.row      = row_cnt;
  assign rd.col      = col_cnt;
  assign rd.eol      = rd_valid_q & eol_raw;
  assign rd.eof      = rd_valid_q & eof_raw;

  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_frame_addr_gen.sv
// Directed bench for frame_addr_gen: expected pixel tuples are queued when a
// frame is started and popped as the DUT hands out addresses.
module tb_frame_addr_gen;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [31:0] width;
  logic [31:0] height;
  logic [31:0] base;
  logic        busy;
  logic        done;
  logic        cfg_err;

  frame_addr_gen_if #(
    .BUSWIDTH (32),
    .DIM_BITS (16)
  ) rd_bus ();

  frame_addr_gen #(
    .BUSWIDTH        (32),
    .DIM_BITS        (16),
    .BYTES_PER_PIXEL (1)
  ) dut (
    .ahb_hclk         (clk),
    .n_rst            (n_rst),
    .start            (start),
    .width            (width),
    .height           (height),
    .readStartAddress (base),
    .rd               (rd_bus),
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] row;
    logic [15:0] col;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  // chg_w > 0 rewrites the width input mid-frame; stop_after > 0 abandons the
  // walk after that many handshakes.
  task automatic run_frame(input int w, input int h, input logic [31:0] b, input int mode,
                           input int chg_w, input int stop_after);
    int          hs;
    int          cyc;
    logic [31:0] a;
    hs  = 0;
    cyc = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        a = b + 32'(r * w + c);
        sb.push_back('{addr: a, row: 16'(r), col: 16'(c),
                       eol: (c == w - 1), eof: (c == w - 1) && (r == h - 1)});
      end
    end
    width           = 32'(w);
    height          = 32'(h);
    base            = b;
    start           = 1'b1;
    rd_bus.rd_ready = 1'b1;
    @(negedge clk);
    chk("load_no_valid", rd_bus.rd_valid, 0);
    @(negedge clk);
    chk("first_valid", rd_bus.rd_valid, 1);
    chk("busy_run", busy, 1);
    while (sb.size() > 0 && cyc < 200 && !(stop_after > 0 && hs == stop_after)) begin
      if (cyc == 1 && chg_w > 0) width = 32'(chg_w);
      rd_bus.rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      chk("valid_held", rd_bus.rd_valid, 1);
      if (rd_bus.rd_valid) begin
        chk("addr", rd_bus.rd_addr, sb[0].addr);
        chk("row", rd_bus.row, sb[0].row);
        chk("col", rd_bus.col, sb[0].col);
        chk("eol", rd_bus.eol, sb[0].eol);
        chk("eof", rd_bus.eof, sb[0].eof);
        if (rd_bus.rd_ready) begin
          void'(sb.pop_front());
          hs++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    if (stop_after == 0) begin
      chk("timeout_left", sb.size(), 0);
      if (mode == 0) chk("throughput", cyc, w * h);
      chk("done_set", done, 1);
      chk("busy_clear", busy, 0);
      chk("valid_after_done", rd_bus.rd_valid, 0);
      chk("eof_after_done", rd_bus.eof, 0);
    end
  endtask

  initial begin
    n_rst           = 1'b0;
    start           = 1'b0;
    width           = '0;
    height          = '0;
    base            = '0;
    rd_bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", rd_bus.rd_valid, 0);
    chk("rst_addr", rd_bus.rd_addr, 0);
    chk("rst_row", rd_bus.row, 0);
    chk("rst_col", rd_bus.col, 0);
    chk("rst_eol", rd_bus.eol, 0);
    chk("rst_eof", rd_bus.eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Basic 4x3 walk at full throughput.
    run_frame(4, 3, 32'h1000, 0, 0, 0);

    // Start still high: no second frame.
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_valid", rd_bus.rd_valid, 0);
      chk("hold_done", done, 1);
    end

    // Drop start for a cycle, then a 1x1 frame.
    start = 1'b0;
    @(negedge clk);
    chk("done_cleared", done, 0);
    run_frame(1, 1, 32'h40, 0, 0, 0);
    start = 1'b0;
    @(negedge clk);

    // Backpressure on a 2x2 frame.
    run_frame(2, 2, 32'h20, 1, 0, 0);
    start = 1'b0;
    @(negedge clk);

    // Width rewritten mid-frame must not affect a 3x2 walk.
    run_frame(3, 2, 32'h300, 0, 9, 0);
    start = 1'b0;
    @(negedge clk);

    // Zero width.
    width  = 32'h0;
    height = 32'h5;
    start  = 1'b1;
    @(negedge clk);
    chk("err_not_yet", cfg_err, 0);
    @(negedge clk);
    chk("err_zero_w", cfg_err, 1);
    chk("err_done", done, 0);
    chk("err_busy", busy, 0);
    repeat (3) begin
      chk("err_no_valid", rd_bus.rd_valid, 0);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    chk("err_cleared", cfg_err, 0);

    // Width beyond DIM_BITS.
    width  = 32'h10000;
    height = 32'h1;
    start  = 1'b1;
    repeat (2) @(negedge clk);
    chk("err_wide_w", cfg_err, 1);
    chk("err_wide_valid", rd_bus.rd_valid, 0);
    start = 1'b0;
    @(negedge clk);

    // Reset after 5 handshakes of an 8x8 frame.
    run_frame(8, 8, 32'h5000, 0, 0, 5);
    n_rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", rd_bus.rd_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_row", rd_bus.row, 0);
    chk("mrst_col", rd_bus.col, 0);
    chk("mrst_addr", rd_bus.rd_addr, 0);
    start = 1'b0;
    n_rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("mrst_no_eof", rd_bus.eof, 0);
      chk("mrst_idle_valid", rd_bus.rd_valid, 0);
    end
    sb.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_addr_gen.md
Name: frame_addr_gen

Overview:
- Downstream consumer of the AHB configuration slave.
- Latches the frame geometry and read base address when the slave's kickstart enable rises.
- Walks the frame in raster order and issues one pixel read address per valid/ready handshake to the pixel-fetch master.
- Flags end-of-row and end-of-frame, and signals completion or configuration error back to the top level.

Parameters:
- BUSWIDTH, 32, width of address and configuration buses.
- DIM_BITS, 16, usable bits of width/height; configured values at or above 2^DIM_BITS are errors.
- BYTES_PER_PIXEL, 1, address stride per pixel.

Ports:
- ahb_hclk  in  1  system/bus clock; all logic on rising edge.
- n_rst  in  1  synchronous active-low reset.
- start  in  1  level enable from the configuration slave; the rising edge starts a frame.
- width  in  BUSWIDTH  frame width in pixels.
- height  in  BUSWIDTH  frame height in pixels.
- readStartAddress  in  BUSWIDTH  byte address of pixel (0,0).
- rd_ready  in  1  fetch master accepts rd_addr this cycle.
- rd_valid  out  1  rd_addr is valid.
- rd_addr  out  BUSWIDTH  current pixel byte address.
- row  out  DIM_BITS  row index of rd_addr.
- col  out  DIM_BITS  column index of rd_addr.
- eol  out  1  current address is the last column of its row.
- eof  out  1  current address is the last pixel of the frame.
- busy  out  1  frame walk in progress.
- done  out  1  frame completed (sticky).
- cfg_err  out  1  invalid geometry latched (sticky).

Behaviour:
- Clock and reset: one clock, ahb_hclk. Reset is synchronous and active-low on n_rst, sampled on the ahb_hclk rising edge.
- Reset values: all outputs 0. State IDLE. start_q = 0. Latched width/height/base = 0.
- start_pulse = start & ~start_q, where start_q is start registered every cycle. A start held high from reset release counts as one edge.
- FSM states: IDLE, LOAD, RUN, DONE, ERR.
- IDLE -> LOAD on start_pulse.
- In LOAD (1 cycle), the block latches width, height and readStartAddress, then checks geometry:
  - width==0, height==0, or any bit at or above DIM_BITS set in either -> ERR.
  - Otherwise -> RUN with row=0, col=0, rd_addr=base.
- RUN:
  - rd_valid=1 and busy=1.
  - rd_addr, row and col hold stable while rd_valid & ~rd_ready.
  - On handshake (rd_valid & rd_ready):
    - If col != w-1: col+1, rd_addr += BYTES_PER_PIXEL.
    - Else if row != h-1: col=0, row+1, rd_addr += BYTES_PER_PIXEL (contiguous rows, no pitch).
    - Else: -> DONE, rd_valid=0 the next cycle.
  - eol = (col==w-1); eof = eol & (row==h-1). Both are combinational from registered counters and qualified by rd_valid.
- Latency: first rd_valid is 2 cycles after the cycle start rises (edge detect, LOAD). Throughput is 1 address per cycle when rd_ready is held high. An N-pixel frame takes N handshakes.
- DONE: done=1, busy=0, rd_valid=0. Stays until start is low for a cycle, then -> IDLE with done cleared.
- ERR: cfg_err=1, done=0, rd_valid=0. Exits to IDLE only when start goes low, which clears cfg_err.
- Configuration inputs are ignored outside LOAD. Changes mid-frame have no effect.
- A start_pulse while in RUN/DONE/ERR is ignored. A new frame requires start low, then high.
- Address arithmetic is modulo 2^BUSWIDTH; wrap past the top of the address space is not flagged.
- 1x1 frame: one address with eol=eof=1, then DONE.
- Reset mid-RUN: next cycle all outputs are 0 and state is IDLE; no further handshakes.

Decomposition:
- Shared package edge_pkg holds:
  - fag_state_t enum (IDLE, LOAD, RUN, DONE, ERR).
  - DIM_BITS default.
  - BYTES_PER_PIXEL default.
- One natural sub-module: raster_counter (col/row counters with enable, wrap at latched w/h, eol/eof outputs).
- Address register and FSM stay in frame_addr_gen.

Test Plan:
- Basic walk: width=4, height=3, base=0x1000, rd_ready=1 -> 12 addresses 0x1000..0x100B on consecutive cycles. eol at col=3 each row, eof only on 0x100B. done=1 the cycle after.
- Backpressure: width=2, height=2, base=0x20; rd_ready toggles 1,0,0,1,... -> rd_addr/row/col stable while stalled. Sequence 0x20,0x21,0x22,0x23 with no skips or duplicates.
- Config error: width=0, height=5 -> cfg_err=1 two cycles after start, rd_valid never asserts. Separately, width=0x10000 with DIM_BITS=16 -> cfg_err=1.
- Restart handling: after done, hold start high -> no second frame. Drop start one cycle and raise it with width=1, height=1, base=0x40 -> single address 0x40 with eol=eof=1, done re-asserts.
- Reset mid-frame: width=8, height=8, assert n_rst=0 after 5 handshakes -> next cycle rd_valid=0, busy=0, row=col=0, rd_addr=0. State is IDLE and the bench checks no eof occurs.
- Latching: change width to 9 during RUN of a 3x2 frame -> still exactly 6 addresses, eol at col=2.
